// File: rtl/pipe_stage_chain.sv
// Parametrised chain of pipeline registers with per-stage valid bits, stall/flush control
// and saturating bubble/flush event counters. Stage 0 is youngest, STAGES-1 is oldest.
module pipe_stage_chain #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [15:0]               bubble_cnt,
    output logic [15:0]               flush_cnt
);

    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0]  data_q, data_d;
    logic [15:0]                   bubble_cnt_q, bubble_cnt_d;
    logic [15:0]                   flush_cnt_q, flush_cnt_d;

    // kill[i]: some flush bit at index >= i; held[i]: some stall bit at index >= i.
    logic [STAGES-1:0] kill, held;
    logic              kill_any, stall_any;
    logic              bubble_inc;

    always_comb begin
        kill_any  = 1'b0;
        stall_any = 1'b0;
        kill      = '0;
        held      = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            kill_any  = kill_any | flush[i];
            stall_any = stall_any | stall[i];
            kill[i]   = kill_any;
            held[i]   = stall_any;
        end
    end

    assign in_ready = (stall == '0) && (flush == '0);

    // A bubble is inserted only when an unflushed stall sits below the oldest stage.
    assign bubble_inc = ~stall[STAGES-1] & (|(held & ~kill));

    always_comb begin
        valid_d = '0;
        data_d  = '0;

        if (kill[0]) begin
            valid_d[0] = 1'b0;
            data_d[0]  = '0;
        end else if (held[0]) begin
            valid_d[0] = valid_q[0];
            data_d[0]  = data_q[0];
        end else begin
            valid_d[0] = in_valid;
            data_d[0]  = in_valid ? in_data : '0;
        end

        for (int i = 1; i < STAGES; i++) begin
            if (kill[i]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = '0;
            end else if (held[i]) begin
                valid_d[i] = valid_q[i];
                data_d[i]  = data_q[i];
            end else if (held[i-1] || kill[i-1]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = '0;
            end else begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bubble_inc && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
        if ((flush != '0) && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            data_q       <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stage_valid = valid_q;
    assign stage_data  = data_q;
    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[STAGES-1];
    assign bubble_cnt  = bubble_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule
